// File: rtl/dii_package.sv
// Shared DI definitions: payload flit type and datapath widths.
package dii_package;

  localparam int unsigned DII_PAYLOAD_WIDTH = 16;
  localparam int unsigned DII_WORD_WIDTH    = 32;

  typedef struct packed {
    logic                         valid;
    logic                         last;
    logic [DII_PAYLOAD_WIDTH-1:0] data;
  } dii_flit;

endpackage

// File: rtl/dii_payload_packer.sv
// Packs 16-bit payload flits into little-endian 32-bit words with a half-word
// keep mask and word-level last; counts completed messages.
module dii_payload_packer
  import dii_package::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  dii_flit                   in_flit,
  output logic                      in_ready,
  output logic [DII_WORD_WIDTH-1:0] out_data,
  output logic [1:0]                out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_WIDTH-1:0]      msg_count
);

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } half_state_t;

  half_state_t                  half_state;
  half_state_t                  half_next;
  logic [DII_PAYLOAD_WIDTH-1:0] lo_q;

  logic                         accept;
  logic                         handshake;
  logic                         store_lo;
  logic                         load;
  logic [DII_WORD_WIDTH-1:0]    load_data;
  logic [1:0]                   load_keep;
  logic                         load_last;

  // Ready depends only on the output slot, never on the assembly state.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_flit.valid && in_ready;
  assign handshake = out_valid && out_ready;

  always_comb begin
    half_next = half_state;
    store_lo  = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_keep = '0;
    load_last = 1'b0;
    if (accept) begin
      case (half_state)
        LO: begin
          if (in_flit.last) begin
            load      = 1'b1;
            load_data = {{DII_PAYLOAD_WIDTH{1'b0}}, in_flit.data};
            load_keep = 2'b01;
            load_last = 1'b1;
          end else begin
            store_lo  = 1'b1;
            half_next = HI;
          end
        end
        HI: begin
          load      = 1'b1;
          load_data = {in_flit.data, lo_q};
          load_keep = 2'b11;
          load_last = in_flit.last;
          half_next = LO;
        end
        default: half_next = LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_state <= LO;
      lo_q       <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      msg_count  <= '0;
    end else begin
      half_state <= half_next;
      if (store_lo) begin
        lo_q <= in_flit.data;
      end
      // A load in the handshake cycle overwrites the departing word directly.
      if (load) begin
        out_data  <= load_data;
        out_keep  <= load_keep;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake && out_last) begin
        msg_count <= msg_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dii_payload_packer.sv
// Directed table plus hand sequences and a random scoreboard for the packer.
module tb_dii_payload_packer;
  import dii_package::*;

  logic        clk = 1'b0;
  logic        rst;
  dii_flit     in_flit;
  logic        out_ready;
  logic        in_ready, in_ready2;
  logic [31:0] out_data, out_data2;
  logic [1:0]  out_keep, out_keep2;
  logic        out_last, out_last2;
  logic        out_valid, out_valid2;
  logic [15:0] msg_count;
  logic [1:0]  msg_count2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  dii_payload_packer dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .msg_count(msg_count)
  );

  dii_payload_packer #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_ready(in_ready2),
    .out_data(out_data2), .out_keep(out_keep2), .out_last(out_last2),
    .out_valid(out_valid2), .out_ready(out_ready), .msg_count(msg_count2)
  );

  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] d;
    logic        ordy;
    logic        e_rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_keep;
    logic        e_last;
    int          e_cnt;
  } vec_t;

  vec_t tbl[11];

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  keep;
    logic        last;
  } word_t;

  word_t sbq[$];

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [15:0] d, input logic r);
    in_flit.valid = v;
    in_flit.last  = l;
    in_flit.data  = d;
    out_ready     = r;
  endtask

  task automatic check_counts(input string name);
    check({name, "_cnt"},  35'(msg_count),  35'(exp_cnt[15:0]));
    check({name, "_cnt2"}, 35'(msg_count2), 35'(exp_cnt[1:0]));
  endtask

  task automatic check_word(input string name, input logic [31:0] d, input logic [1:0] k, input logic l);
    check({name, "_valid"}, 35'(out_valid), 35'(1));
    check({name, "_word"}, {out_data, out_keep, out_last}, {d, k, l});
  endtask

  function automatic vec_t mk(input logic v, input logic l, input logic [15:0] d,
                              input logic ordy, input logic e_rdy, input logic e_valid,
                              input logic [31:0] e_data, input logic [1:0] e_keep,
                              input logic e_last, input int e_cnt);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.ordy = ordy; t.e_rdy = e_rdy; t.e_valid = e_valid;
    t.e_data = e_data; t.e_keep = e_keep; t.e_last = e_last; t.e_cnt = e_cnt;
    return t;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, hs, pv, phs;
    logic [31:0] pdata;
    logic        m_hi;
    logic [15:0] m_lo;
    int          drain;

    tbl[0]  = mk(1, 0, 16'h1111, 1, 1, 0, 32'h0,         2'b00, 0, 0);
    tbl[1]  = mk(1, 0, 16'h2222, 1, 1, 1, 32'h2222_1111, 2'b11, 0, 0);
    tbl[2]  = mk(1, 0, 16'h3333, 1, 1, 0, 32'h0,         2'b00, 0, 0);
    tbl[3]  = mk(1, 1, 16'h4444, 1, 1, 1, 32'h4444_3333, 2'b11, 1, 0);
    tbl[4]  = mk(0, 0, 16'h0,    1, 1, 0, 32'h0,         2'b00, 0, 1);
    tbl[5]  = mk(1, 0, 16'hAAAA, 1, 1, 0, 32'h0,         2'b00, 0, 1);
    tbl[6]  = mk(1, 0, 16'hBBBB, 1, 1, 1, 32'hBBBB_AAAA, 2'b11, 0, 1);
    tbl[7]  = mk(1, 1, 16'hCCCC, 1, 1, 1, 32'h0000_CCCC, 2'b01, 1, 1);
    tbl[8]  = mk(0, 0, 16'h0,    1, 1, 0, 32'h0,         2'b00, 0, 2);
    tbl[9]  = mk(1, 1, 16'h5A5A, 1, 1, 1, 32'h0000_5A5A, 2'b01, 1, 2);
    tbl[10] = mk(0, 0, 16'h0,    1, 1, 0, 32'h0,         2'b00, 0, 3);

    rst = 1'b1;
    drive(0, 0, 16'h0, 1);
    tick;
    tick;
    rst = 1'b0;
    check("reset_out", {out_data, out_keep, out_last}, 35'h0);
    check("reset_valid", 35'(out_valid), 35'(0));
    check("reset_in_ready", 35'(in_ready), 35'(1));
    check_counts("reset");

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), 35'(in_ready), 35'(tbl[i].e_rdy));
      tick;
      exp_cnt = tbl[i].e_cnt;
      check($sformatf("v%0d_valid", i), 35'(out_valid), 35'(tbl[i].e_valid));
      if (tbl[i].e_valid)
        check($sformatf("v%0d_word", i), {out_data, out_keep, out_last},
              {tbl[i].e_data, tbl[i].e_keep, tbl[i].e_last});
      check_counts($sformatf("v%0d", i));
    end

    // Output stall with a word-completing flit waiting at the input.
    drive(1, 0, 16'h0101, 1);
    tick;
    drive(1, 0, 16'h0202, 0);
    #1;
    check("stall_pre_in_ready", 35'(in_ready), 35'(1));
    tick;
    check_word("stall_pending", 32'h0202_0101, 2'b11, 0);
    drive(1, 1, 16'h0303, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_in_ready", k), 35'(in_ready), 35'(0));
      tick;
      check_word($sformatf("stall%0d", k), 32'h0202_0101, 2'b11, 0);
      check_counts($sformatf("stall%0d", k));
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 35'(in_ready), 35'(1));
    tick;
    check_word("release_load", 32'h0000_0303, 2'b01, 1);
    drive(0, 0, 16'h0, 1);
    tick;
    exp_cnt = 4;
    check("release_drain_valid", 35'(out_valid), 35'(0));
    check_counts("release_drain");

    // Reset while holding a low half.
    drive(1, 0, 16'h1234, 1);
    tick;
    drive(0, 0, 16'h0, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    check("midrst_out", {out_data, out_keep, out_last}, 35'h0);
    check("midrst_valid", 35'(out_valid), 35'(0));
    check_counts("midrst");
    drive(1, 1, 16'h9999, 1);
    tick;
    check_word("midrst_9999", 32'h0000_9999, 2'b01, 1);
    drive(0, 0, 16'h0, 1);
    tick;
    exp_cnt = 1;
    check_counts("midrst_done");

    // Back-to-back single-flit messages; the 2-bit counter wraps.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 16'(16'h0F00 + k), 1);
      tick;
      if (k > 0) exp_cnt++;
      check_word($sformatf("single%0d", k), 32'(16'h0F00 + k), 2'b01, 1);
      check_counts($sformatf("single%0d", k));
    end
    drive(0, 0, 16'h0, 1);
    tick;
    exp_cnt++;
    check_counts("single_done");

    // Random valid/ready stress against a flit-level scoreboard.
    m_hi  = 1'b0;
    m_lo  = '0;
    drain = 0;
    for (int c = 0; c < 2000 + 40; c++) begin
      if (c < 2000) begin
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
              16'($urandom), $urandom_range(0, 9) < 7);
      end else begin
        drive(0, 0, 16'h0, 1);
        if (sbq.size() == 0 && !out_valid) break;
        drain++;
      end
      #1;
      check("rnd_in_ready", 35'(in_ready), 35'(!out_valid || out_ready));
      acc = in_flit.valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (sbq.size() == 0) begin
          check("rnd_unexpected_word", {out_data, out_keep, out_last}, 35'h7_FFFF_FFFF);
        end else begin
          word_t w;
          w = sbq.pop_front();
          check("rnd_word", {out_data, out_keep, out_last}, {w.data, w.keep, w.last});
          if (w.last) exp_cnt++;
        end
      end
      if (acc) begin
        word_t w;
        if (!m_hi) begin
          if (in_flit.last) begin
            w.data = {16'h0, in_flit.data}; w.keep = 2'b01; w.last = 1'b1;
            sbq.push_back(w);
          end else begin
            m_lo = in_flit.data;
            m_hi = 1'b1;
          end
        end else begin
          w.data = {in_flit.data, m_lo}; w.keep = 2'b11; w.last = in_flit.last;
          sbq.push_back(w);
          m_hi = 1'b0;
        end
      end
      pv    = out_valid;
      phs   = hs;
      pdata = out_data;
      tick;
      if (pv && !phs && !acc) begin
        check("rnd_hold_valid", 35'(out_valid), 35'(1));
        check("rnd_hold_data", 35'(out_data), 35'(pdata));
      end
      check_counts("rnd");
    end
    check("rnd_drain_empty", 35'(sbq.size()), 35'(0));
    check("rnd_drain_valid", 35'(out_valid), 35'(0));
    check("rnd_drain_bound", 35'(drain < 40), 35'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
